fifo_seg_display: RTL and testbench



---
 rtl/fifo_seg_display.sv | 216 +++++++++++++++++++++
 tb/tb_fifo_seg_display.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_seg_display.sv
// Rate-limited consumer of the board FIFO: keeps the last four popped bytes as eight hex digits.
// Build option SEG_DP_MARK_EN lights the decimal point on the two digits of the newest byte.
module fifo_seg_display #(
    parameter int POP_DIV = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic [7:0]       fifo_rd_data,
    output logic             fifo_rd_en,
    input  logic             clear,
    output logic [7:0]       seg0,
    output logic [7:0]       seg1,
    output logic [7:0]       seg2,
    output logic [7:0]       seg3,
    output logic [7:0]       seg4,
    output logic [7:0]       seg5,
    output logic [7:0]       seg6,
    output logic [7:0]       seg7,
    output logic [CNT_W-1:0] byte_cnt,
    output logic             busy
);

    localparam int TMR_W = (POP_DIV > 1) ? $clog2(POP_DIV) : 1;
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(POP_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               rd_en_q, rd_en_d;
    logic               busy_q, busy_d;
    logic [31:0]        hist_q, hist_d;
    logic [3:0]         valid_q, valid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [7:0]         seg_q [8];
    logic [7:0]         seg_d [8];

    // Active-low glyph for one hex nibble: bit7=a .. bit1=g, bit0=dp off
    function automatic logic [7:0] hex_glyph(input logic [3:0] nib);
        logic [7:0] g;
        case (nib)
            4'h0:    g = 8'h03;
            4'h1:    g = 8'h9F;
            4'h2:    g = 8'h25;
            4'h3:    g = 8'h0D;
            4'h4:    g = 8'h99;
            4'h5:    g = 8'h49;
            4'h6:    g = 8'h41;
            4'h7:    g = 8'h1F;
            4'h8:    g = 8'h01;
            4'h9:    g = 8'h09;
            4'hA:    g = 8'h11;
            4'hB:    g = 8'hC1;
            4'hC:    g = 8'h63;
            4'hD:    g = 8'h85;
            4'hE:    g = 8'h61;
            4'hF:    g = 8'h71;
            default: g = 8'hFF;
        endcase
        return g;
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clear forces IDLE from anywhere
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if ((timer_q == '0) && !fifo_empty) begin
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_READ:    state_d = ST_CAPTURE;
                ST_CAPTURE: state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // Moore outputs, registered so they follow the state register exactly
    always_comb begin
        if (state_d == ST_READ) begin
            rd_en_d = 1'b1;
        end else begin
            rd_en_d = 1'b0;
        end
        if (state_d != ST_IDLE) begin
            busy_d = 1'b1;
        end else begin
            busy_d = 1'b0;
        end
    end

    // History, count and pacing timer
    always_comb begin
        hist_d  = hist_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;
        if (clear) begin
            hist_d  = 32'h0000_0000;
            valid_d = 4'b0000;
            cnt_d   = '0;
            timer_d = TMR_RELOAD;
        end else begin
            if (state_q == ST_CAPTURE) begin
                hist_d  = {hist_q[23:0], fifo_rd_data};
                valid_d = {valid_q[2:0], 1'b1};
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end else begin
                hist_d  = hist_q;
                valid_d = valid_q;
            end
            // The reload is anchored to the pop start so pop starts are max(POP_DIV,3) apart
            if (state_d == ST_READ) begin
                timer_d = TMR_RELOAD;
            end else if (timer_q != '0) begin
                timer_d = timer_q - TMR_W'(1);
            end else begin
                timer_d = '0;
            end
        end
    end

    // Digit drivers: slot k (0 = newest) feeds seg(2k) low nibble and seg(2k+1) high nibble
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            seg_d[k] = 8'hFF;
        end
        if (clear) begin
            for (int k = 0; k < 8; k++) begin
                seg_d[k] = 8'hFF;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (valid_q[k]) begin
                    seg_d[2*k]   = hex_glyph(hist_q[8*k +: 4]);
                    seg_d[2*k+1] = hex_glyph(hist_q[8*k+4 +: 4]);
                end else begin
                    seg_d[2*k]   = 8'hFF;
                    seg_d[2*k+1] = 8'hFF;
                end
            end
`ifdef SEG_DP_MARK_EN
            if (valid_q[0]) begin
                seg_d[0][0] = 1'b0;
                seg_d[1][0] = 1'b0;
            end else begin
                seg_d[0][0] = 1'b1;
                seg_d[1][0] = 1'b1;
            end
`endif
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
            hist_q  <= 32'h0000_0000;
            valid_q <= 4'b0000;
            cnt_q   <= '0;
            timer_q <= TMR_RELOAD;
            for (int k = 0; k < 8; k++) begin
                seg_q[k] <= 8'hFF;
            end
        end else begin
            rd_en_q <= rd_en_d;
            busy_q  <= busy_d;
            hist_q  <= hist_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            for (int k = 0; k < 8; k++) begin
                seg_q[k] <= seg_d[k];
            end
        end
    end

    assign fifo_rd_en = rd_en_q;
    assign busy       = busy_q;
    assign byte_cnt   = cnt_q;
    assign seg0       = seg_q[0];
    assign seg1       = seg_q[1];
    assign seg2       = seg_q[2];
    assign seg3       = seg_q[3];
    assign seg4       = seg_q[4];
    assign seg5       = seg_q[5];
    assign seg6       = seg_q[6];
    assign seg7       = seg_q[7];

endmodule

// File: tb/tb_fifo_seg_display.sv
// Bench for fifo_seg_display: emulated registered-read FIFO, cycle-level reference model,
// directed scenarios followed by randomized pushes and clears.
module tb_fifo_seg_display;

    localparam int POP_DIV = 4;
    localparam int CNT_W   = 16;
    localparam int GAP     = (POP_DIV - 1 > 2) ? POP_DIV - 1 : 2;
`ifdef SEG_DP_MARK_EN
    localparam bit DP_MARK = 1'b1;
`else
    localparam bit DP_MARK = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             fifo_empty;
    logic [7:0]       fifo_rd_data;
    logic             fifo_rd_en;
    logic             clear;
    logic [7:0]       seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7;
    logic [CNT_W-1:0] byte_cnt;
    logic             busy;

    always #5 clk = ~clk;

    fifo_seg_display #(.POP_DIV(POP_DIV), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
        .fifo_rd_en(fifo_rd_en), .clear(clear),
        .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3),
        .seg4(seg4), .seg5(seg5), .seg6(seg6), .seg7(seg7),
        .byte_cnt(byte_cnt), .busy(busy)
    );

    // Upstream FIFO: data appears the cycle after a pop request
    logic [7:0] fq[$];
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (fq.size() > 0) fifo_rd_data <= fq.pop_front();
            else               fifo_rd_data <= 8'hEE;
        end
    end

    logic [7:0] glyph_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                                   8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

    // Reference model: cycle index, scheduled pop, earliest eligible idle cycle, history
    int         n, read_at, ready_at, cnt;
    logic [7:0] hist[$];
    logic [7:0] exp_seg [8];
    logic [7:0] exp_byte;
    int         errors = 0;
    int         checks = 0;

    function automatic logic [7:0] digit(input logic [3:0] nib, input bit mark);
        logic [7:0] g;
        g = glyph_tab[nib];
        if (mark) g[0] = 1'b0;
        return g;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, n);
        end
    endtask

    task automatic model_reset();
        n        = 0;
        read_at  = -100;
        ready_at = POP_DIV - 1;
        cnt      = 0;
        hist.delete();
        for (int k = 0; k < 8; k++) exp_seg[k] = 8'hFF;
    endtask

    task automatic check_all();
        logic [7:0] s [8];
        s = '{seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7};
        chk("rd_en", {31'd0, fifo_rd_en}, {31'd0, (n == read_at)});
        chk("busy", {31'd0, busy}, {31'd0, (n == read_at) || (n == read_at + 1)});
        chk("byte_cnt", {16'd0, byte_cnt}, cnt);
        for (int k = 0; k < 8; k++) chk($sformatf("seg%0d", k), {24'd0, s[k]}, {24'd0, exp_seg[k]});
    endtask

    // One clock cycle: drive inputs at the falling edge, check, advance the model
    task automatic step(input bit clr, input bit do_push, input logic [7:0] pb);
        logic [7:0] nseg [8];
        bit busy_now;
        if (do_push) fq.push_back(pb);
        clear      = clr;
        fifo_empty = (fq.size() == 0);
        check_all();
        if (n == read_at) exp_byte = (fq.size() > 0) ? fq[0] : 8'hEE;
        busy_now = (n == read_at) || (n == read_at + 1);
        for (int k = 0; k < 4; k++) begin
            if (k < hist.size()) begin
                nseg[2*k]   = digit(hist[k][3:0], DP_MARK && (k == 0));
                nseg[2*k+1] = digit(hist[k][7:4], DP_MARK && (k == 0));
            end else begin
                nseg[2*k]   = 8'hFF;
                nseg[2*k+1] = 8'hFF;
            end
        end
        if (clr) begin
            for (int k = 0; k < 8; k++) nseg[k] = 8'hFF;
            hist.delete();
            cnt      = 0;
            ready_at = n + POP_DIV;
            read_at  = -100;
        end else begin
            if (n == read_at + 1) begin
                hist.push_front(exp_byte);
                if (hist.size() > 4) void'(hist.pop_back());
                if (cnt < (1 << CNT_W) - 1) cnt++;
            end
            if (!busy_now && n >= ready_at && !fifo_empty) begin
                read_at  = n + 1;
                ready_at = n + 1 + GAP;
            end
        end
        exp_seg = nseg;
        n++;
        @(negedge clk);
    endtask

    initial begin
        bit found;
        rst = 1'b0; clear = 1'b0; fifo_empty = 1'b0; fifo_rd_data = 8'h00;
        fq.push_back(8'hC4);
        repeat (3) @(negedge clk);
        // Reset with data waiting upstream
        chk("reset_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_cnt", {16'd0, byte_cnt}, 32'd0);
        chk("reset_seg0", {24'd0, seg0}, 32'hFF);
        chk("reset_seg7", {24'd0, seg7}, 32'hFF);
        fq.delete();
        fifo_empty = 1'b1;
        rst = 1'b1;
        model_reset();

        // Single pop of 5A arriving in cycle 5
        repeat (5) step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h5A);
        repeat (8) step(1'b0, 1'b0, 8'h00);
        chk("single_seg0", {24'd0, seg0}, DP_MARK ? 32'h10 : 32'h11);
        chk("single_seg1", {24'd0, seg1}, DP_MARK ? 32'h48 : 32'h49);
        chk("single_seg2", {24'd0, seg2}, 32'hFF);
        chk("single_cnt", {16'd0, byte_cnt}, 32'd1);

        // Wrap: five bytes after a clear, oldest is dropped
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h01);
        step(1'b0, 1'b1, 8'h03);
        step(1'b0, 1'b1, 8'h05);
        step(1'b0, 1'b1, 8'h08);
        step(1'b0, 1'b1, 8'h0F);
        repeat (25) step(1'b0, 1'b0, 8'h00);
        chk("wrap_seg0", {24'd0, seg0}, DP_MARK ? 32'h70 : 32'h71);
        chk("wrap_seg1", {24'd0, seg1}, DP_MARK ? 32'h02 : 32'h03);
        chk("wrap_seg2", {24'd0, seg2}, 32'h01);
        chk("wrap_seg4", {24'd0, seg4}, 32'h49);
        chk("wrap_seg6", {24'd0, seg6}, 32'h0D);
        chk("wrap_seg7", {24'd0, seg7}, 32'h03);
        chk("wrap_cnt", {16'd0, byte_cnt}, 32'd5);

        // Empty stall long after the timer expired
        repeat (20) step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'hA7);
        repeat (6) step(1'b0, 1'b0, 8'h00);

        // Clear coincident with CAPTURE of 33
        step(1'b0, 1'b1, 8'h33);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (n == read_at + 1) begin
                step(1'b1, 1'b0, 8'h00);
                found = 1'b1;
            end else begin
                step(1'b0, 1'b0, 8'h00);
            end
        end
        chk("clear_capture_reached", {31'd0, found}, 32'd1);
        repeat (10) step(1'b0, 1'b0, 8'h00);

        // Randomized pushes and occasional clears
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0, 8'($urandom));
        end

        // Asynchronous reset while in READ
        step(1'b1, 1'b0, 8'h00);
        fq.delete();
        step(1'b0, 1'b1, 8'h80);
        for (int i = 0; i < 20 && n != read_at; i++) step(1'b0, 1'b0, 8'h00);
        chk("pre_reset_rd_en", {31'd0, fifo_rd_en}, 32'd1);
        rst = 1'b0;
        #1;
        chk("async_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        chk("async_busy", {31'd0, busy}, 32'd0);
        chk("async_cnt", {16'd0, byte_cnt}, 32'd0);
        chk("async_seg1", {24'd0, seg1}, 32'hFF);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat (10) step(1'b0, 1'b0, 8'h00);
        chk("dp_seg0", {24'd0, seg0}, DP_MARK ? 32'h02 : 32'h03);
        chk("dp_seg1", {24'd0, seg1}, DP_MARK ? 32'h00 : 32'h01);
        chk("dp_seg2", {24'd0, seg2}, 32'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
